// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small read FIFO on the SOC IO page.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err flag.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 615000,
  parameter int BAUD_RATE   = 56000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        RXD,
  input  logic        io_sel_data,
  input  logic        io_sel_status,
  input  logic        mem_rstrb,
  output logic [31:0] io_rdata,
  output logic        rx_ready
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL  = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;
`endif

  logic          r_sync1;
  logic          r_rxs;
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_fe;
  logic          r_ov;

  logic          w_tick;
  logic          w_stop_smp;
  logic          w_push;
  logic          w_set_fe;
  logic          w_rd_data;
  logic          w_rd_stat;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf;
  logic          w_pe_bit;
  logic [3:0]    w_cnt4;
  logic [31:0]   w_status;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_rxs   <= r_sync1;
    end
  end

  assign w_tick     = (r_baud == '0);
  assign w_stop_smp = (r_state == S_STOP) && w_tick;
  assign w_set_fe   = w_stop_smp && !r_rxs;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_pe;
  logic w_set_pe;

  assign w_set_pe = (r_state == S_PARITY) && w_tick && (^{r_rxs, r_shift});
  assign w_push   = w_stop_smp && r_rxs && !r_par_bad;
  assign w_pe_bit = r_pe;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_par_bad <= 1'b0;
      r_pe      <= 1'b0;
    end else begin
      if (r_state == S_PARITY && w_tick)
        r_par_bad <= ^{r_rxs, r_shift};
      if (w_set_pe)
        r_pe <= 1'b1;
      else if (w_rd_stat)
        r_pe <= 1'b0;
    end
  end
`else
  assign w_push   = w_stop_smp && r_rxs;
  assign w_pe_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_baud  <= HALF;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else if (r_rxs) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DATA;
            r_baud  <= FULL;
            r_bit   <= '0;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_baud  <= FULL;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else begin
            r_baud  <= FULL;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!w_tick)
            r_baud <= r_baud - 1'b1;
          else
            r_state <= r_rxs ? S_IDLE : S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          // a held-low line must return high before a new start is seen
          if (r_rxs)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_data = io_sel_data & mem_rstrb;
  assign w_rd_stat = io_sel_status & mem_rstrb & ~io_sel_data;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH);
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf     = w_push & w_full & ~w_pop;
  assign w_cnt4    = 4'(r_count);
  assign rx_ready  = ~w_empty;
  assign w_status  = {24'b0, w_cnt4, w_pe_bit, r_fe, r_ov, rx_ready};

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp] <= r_shift;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_fe     <= 1'b0;
      r_ov     <= 1'b0;
      io_rdata <= '0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);

      // a flag raised in the same cycle as a status read survives it
      if (w_set_fe)
        r_fe <= 1'b1;
      else if (w_rd_stat)
        r_fe <= 1'b0;
      if (w_ovf)
        r_ov <= 1'b1;
      else if (w_rd_stat)
        r_ov <= 1'b0;

      if (w_rd_data)
        io_rdata <= w_empty ? 32'h0000_0100 : {24'b0, r_mem[r_rp]};
      else if (w_rd_stat)
        io_rdata <= w_status;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-level receive model checked every cycle,
// plus directed frames with hand-computed read values.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DIV    = 615000 / 56000;
  localparam int DEPTH  = 4;
  // sync (2) + half bit to start centre + 9 bit times to stop centre
  localparam int EV_OFF = 2 + DIV / 2 + 9 * DIV;

  logic        clk;
  logic        RESET;
  logic        RXD;
  logic        io_sel_data;
  logic        io_sel_status;
  logic        mem_rstrb;
  logic [31:0] io_rdata;
  logic        rx_ready;

  int n_checks = 0;
  int n_err    = 0;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(615000),
    .BAUD_RATE  (56000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .RXD          (RXD),
    .io_sel_data  (io_sel_data),
    .io_sel_status(io_sel_status),
    .mem_rstrb    (mem_rstrb),
    .io_rdata     (io_rdata),
    .rx_ready     (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  q[$];
  bit          m_fe;
  bit          m_ov;
  logic [31:0] m_rdata = '0;
  int          arm_seq = 0;
  int          seen_seq = 0;
  logic [7:0]  arm_byte;
  bit          arm_stop;
  int          ev_cnt = -1;
  logic [7:0]  ev_byte;
  bit          ev_stop;

  always @(posedge clk) begin
    int n;
    bit ev_now;
    ev_now = 1'b0;
    if (RESET) begin
      q.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
      m_rdata = '0;
      ev_cnt = -1;
      seen_seq = arm_seq;
    end else begin
      if (ev_cnt > 0) begin
        ev_cnt--;
        if (ev_cnt == 0) ev_now = 1'b1;
      end
      n = q.size();
      if (mem_rstrb && io_sel_data) begin
        if (n > 0) m_rdata = {24'b0, q.pop_front()};
        else       m_rdata = 32'h100;
      end else if (mem_rstrb && io_sel_status) begin
        m_rdata = {24'b0, 4'(n), 1'b0, m_fe, m_ov, n != 0};
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      if (ev_now) begin
        if (ev_stop) begin
          if (q.size() < DEPTH) q.push_back(ev_byte);
          else m_ov = 1'b1;
        end else begin
          m_fe = 1'b1;
        end
      end
      if (arm_seq != seen_seq) begin
        seen_seq = arm_seq;
        ev_cnt   = EV_OFF;
        ev_byte  = arm_byte;
        ev_stop  = arm_stop;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("rx_ready", {31'b0, rx_ready}, {31'b0, q.size() != 0});
    check("io_rdata", io_rdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input bit stat, output logic [31:0] v);
    io_sel_data   = !stat;
    io_sel_status = stat;
    mem_rstrb     = 1'b1;
    @(negedge clk);
    io_sel_data   = 1'b0;
    io_sel_status = 1'b0;
    mem_rstrb     = 1'b0;
    v = io_rdata;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv,
                            input int cut, input int rd_at,
                            input bit rd_stat);
    logic [9:0] bits;
    bits = {stopv, b, 1'b0};
    for (int i = 0; i < 10 * DIV; i++) begin
      if (i >= cut) break;
      if (i == 0) begin
        arm_byte = b;
        arm_stop = stopv;
        arm_seq++;
      end
      RXD           = bits[i / DIV];
      io_sel_data   = (i == rd_at) && !rd_stat;
      io_sel_status = (i == rd_at) && rd_stat;
      mem_rstrb     = (i == rd_at);
      @(negedge clk);
    end
    io_sel_data   = 1'b0;
    io_sel_status = 1'b0;
    mem_rstrb     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    RESET = 1'b1;
    RXD = 1'b1;
    io_sel_data = 1'b0;
    io_sel_status = 1'b0;
    mem_rstrb = 1'b0;
    idle(3);
    RESET = 1'b0;
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_ready", {31'b0, rx_ready}, 32'h0);
    idle(5);

    // single byte then data and status reads
    send_frame(8'h55, 1'b1, 100, -1, 1'b0);
    idle(5);
    rd(1'b0, v); check("t1_data", v, 32'h55);
    rd(1'b1, v); check("t1_stat", v, 32'h00);

    // empty read, then strobe with no select holds io_rdata
    rd(1'b0, v); check("t2_empty", v, 32'h100);
    rd(1'b1, v); check("t2_stat", v, 32'h00);
    rd(1'b0, v); check("t2_empty2", v, 32'h100);
    mem_rstrb = 1'b1;
    idle(1);
    mem_rstrb = 1'b0;
    check("t2_hold", io_rdata, 32'h100);

    // overrun: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 100, -1, 1'b0);
      idle(3);
    end
    rd(1'b1, v); check("t3_stat", v, 32'h43);
    for (int i = 1; i <= 4; i++) begin
      rd(1'b0, v); check("t3_drain", v, 32'(i));
    end
    rd(1'b1, v); check("t3_stat2", v, 32'h00);
    rd(1'b0, v); check("t3_empty", v, 32'h100);

    // full FIFO with a pop in the push cycle: no overrun
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i * 16), 1'b1, 100, -1, 1'b0);
      idle(2);
    end
    send_frame(8'h50, 1'b1, 100, EV_OFF, 1'b0);
    check("t7_pop", io_rdata, 32'h10);
    idle(2);
    rd(1'b1, v); check("t7_stat", v, 32'h41);
    for (int i = 2; i <= 5; i++) begin
      rd(1'b0, v); check("t7_drain", v, 32'(i * 16));
    end

    // break with a status read on the frame-error cycle
    send_frame(8'h00, 1'b0, 100, EV_OFF, 1'b1);
    check("t4_rd_preset", io_rdata, 32'h00);
    idle(100);
    RXD = 1'b1;
    idle(20);
    rd(1'b1, v); check("t4_stat", v, 32'h04);
    rd(1'b1, v); check("t4_stat2", v, 32'h00);
    send_frame(8'hA3, 1'b1, 100, -1, 1'b0);
    idle(5);
    rd(1'b0, v); check("t4_data", v, 32'hA3);

    // two-cycle glitch is rejected at the start-bit check
    RXD = 1'b0;
    idle(2);
    RXD = 1'b1;
    idle(30);
    rd(1'b1, v); check("t5_stat", v, 32'h00);
    check("t5_ready", {31'b0, rx_ready}, 32'h0);

    // reset in the middle of data bit 4
    send_frame(8'h11, 1'b1, 100, -1, 1'b0);
    idle(3);
    rd(1'b1, v); check("t6_pre", v, 32'h11);
    send_frame(8'h99, 1'b1, 55, -1, 1'b0);
    RESET = 1'b1;
    RXD = 1'b1;
    #1;
    check("t6_rdata", io_rdata, 32'h0);
    check("t6_ready", {31'b0, rx_ready}, 32'h0);
    idle(2);
    RESET = 1'b0;
    idle(5);
    send_frame(8'h7E, 1'b1, 100, -1, 1'b0);
    idle(5);
    rd(1'b0, v); check("t6_data", v, 32'h7E);
    rd(1'b1, v); check("t6_stat", v, 32'h00);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
